// File: rtl/vote_sampler.sv
// Samples a serial line N_VOTES times, DIV clocks apart, and offers the packed
// vector to the majority voter over a valid/ready handshake.
module vote_sampler #(
  parameter int N_VOTES = 5,
  parameter int DIV     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               din,
  output logic [N_VOTES-1:0] votes,
  output logic               votes_valid,
  input  logic               votes_ready,
  output logic               busy,
  output logic [2:0]         sample_idx
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(N_VOTES - 1);
  localparam logic [2:0]    IDX_MAX  = 3'(N_VOTES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      div_cnt_q, div_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [N_VOTES-1:0] votes_q, votes_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    votes_d   = votes_q;
    valid_d   = valid_q;
    if (clear) begin
      state_d   = S_IDLE;
      div_cnt_d = '0;
      idx_d     = '0;
      votes_d   = '0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_COLLECT;
            div_cnt_d = '0;
            idx_d     = '0;
            votes_d   = '0;
          end
        end
        S_COLLECT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            for (int k = 0; k < N_VOTES; k++)
              if (idx_q == 3'(k)) votes_d[k] = din;
            // saturate so a stray extra tick can never wrap the index
            if (idx_q != IDX_MAX) idx_d = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
              state_d = S_HOLD;
              valid_d = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (valid_q && votes_ready) begin
            valid_d = 1'b0;
            if (start) begin
              state_d   = S_COLLECT;
              div_cnt_d = '0;
              idx_d     = '0;
              votes_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_d = (state_d == S_COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      idx_q     <= '0;
      votes_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      votes_q   <= votes_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign votes       = votes_q;
  assign votes_valid = valid_q;
  assign busy        = busy_q;
  assign sample_idx  = idx_q;

endmodule

// File: tb/tb_vote_sampler.sv
// Directed bench: default 5x4 sampler plus a 1x1 corner instance on the same clock.
module tb_vote_sampler;
  logic       clk = 1'b0;
  logic       rst_n, clear;
  logic       start, din, ready;
  logic [4:0] votes;
  logic       valid, busy;
  logic [2:0] idx;
  logic       start1, din1, ready1;
  logic [0:0] votes1;
  logic       valid1, busy1;
  logic [2:0] idx1;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  vote_sampler #(.N_VOTES(5), .DIV(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .din(din),
    .votes(votes), .votes_valid(valid), .votes_ready(ready),
    .busy(busy), .sample_idx(idx));

  vote_sampler #(.N_VOTES(1), .DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .clear(clear), .din(din1),
    .votes(votes1), .votes_valid(valid1), .votes_ready(ready1),
    .busy(busy1), .sample_idx(idx1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one full collection; start must already have been sampled.
  task automatic collect(input logic [4:0] pat, input string tag);
    for (int k = 0; k < 5; k++) begin
      din = pat[k];
      repeat (3) tick();
      if (k == 4) begin
        chk({tag, "_valid_pre"}, 32'(valid), 32'd0);
        chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
      end
      tick();
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_votes"}, 32'(votes), 32'(pat));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idx"}, 32'(idx), 32'd5);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; din = 1'b0; ready = 1'b0;
    start1 = 1'b0; din1 = 1'b0; ready1 = 1'b0;
    repeat (2) tick();
    chk("rst_votes", 32'(votes), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // async reset mid-collection
    start = 1'b1; tick(); start = 1'b0; din = 1'b1;
    repeat (8) tick();
    chk("pre_rst_idx", 32'(idx), 32'd2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_votes", 32'(votes), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    tick(); rst_n = 1'b1; tick(); tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // basic collection: din 1,0,1,1,0 -> 5'b01101
    start = 1'b1; tick(); start = 1'b0;
    chk("basic_busy0", 32'(busy), 32'd1);
    collect(5'b01101, "basic");

    // backpressure
    for (int i = 0; i < 10; i++) begin
      din = ~din; tick();
      if (i == 3 || i == 9) begin
        chk("bp_votes", 32'(votes), 32'h0d);
        chk("bp_valid", 32'(valid), 32'd1);
      end
    end
    ready = 1'b1; tick(); ready = 1'b0;
    chk("bp_rel_valid", 32'(valid), 32'd0);
    chk("bp_rel_busy", 32'(busy), 32'd0);
    chk("bp_rel_votes", 32'(votes), 32'h0d);
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // back-to-back
    start = 1'b1; tick(); start = 1'b0;
    collect(5'b10011, "b2b_a");
    ready = 1'b1; start = 1'b1; tick(); ready = 1'b0; start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_valid", 32'(valid), 32'd0);
    chk("b2b_votes", 32'(votes), 32'd0);
    chk("b2b_idx", 32'(idx), 32'd0);
    collect(5'b01010, "b2b_b");
    start = 1'b1; tick(); start = 1'b0;
    chk("hold_start_ign", 32'(busy), 32'd0);
    chk("hold_start_valid", 32'(valid), 32'd1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("b2b_idle", 32'(busy), 32'd0);

    // clear priority and abort
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("clr_start_busy", 32'(busy), 32'd0);
    chk("clr_start_idx", 32'(idx), 32'd0);
    start = 1'b1; tick(); start = 1'b0; din = 1'b1;
    repeat (6) tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("restart_ign_idx", 32'(idx), 32'd2);
    repeat (4) tick();
    chk("abort_pre_idx", 32'(idx), 32'd3);
    chk("abort_pre_votes", 32'(votes), 32'h07);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_votes", 32'(votes), 32'd0);
    chk("abort_idx", 32'(idx), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);

    // DIV=1, N_VOTES=1 corner
    din1 = 1'b1; start1 = 1'b1; tick(); start1 = 1'b0;
    chk("c1_busy", 32'(busy1), 32'd1);
    chk("c1_valid_pre", 32'(valid1), 32'd0);
    tick();
    chk("c1_valid", 32'(valid1), 32'd1);
    chk("c1_votes", 32'(votes1), 32'd1);
    chk("c1_idx", 32'(idx1), 32'd1);
    ready1 = 1'b1; tick(); ready1 = 1'b0;
    chk("c1_rel", 32'(valid1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
